uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. Each receiver done pulse writes the received byte. The host side reads bytes through a first-word-fall-through pop interface. The block also reports occupancy, almost-full, and a sticky overflow flag, so software or a consumer FSM can drain bursts without losing data silently.

Parameters:
ADDR_W, 4, log2 of FIFO depth; depth = 2**ADDR_W (16 entries by default).
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2**ADDR_W.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
wr  input  1  write strobe; connects to the receiver's rx_done_tick; single-cycle pulse.
din  input  8  byte to write; sampled only when wr=1.
rd  input  1  pop strobe from consumer; removes the head entry.
dout  output  8  head entry (FWFT); 8'h00 whenever empty=1.
empty  output  1  1 when count==0.
full  output  1  1 when count==2**ADDR_W.
almost_full  output  1  1 when count>=AF_LEVEL.
count  output  ADDR_W+1  current number of stored entries.
overflow  output  1  sticky; set when a write is dropped because the FIFO is full.
clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, async): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs: empty=1, full=0, almost_full=0, dout=8'h00. The storage array is not reset.
- Storage: 2**ADDR_W x 8 register array.
  - Write: mem[wr_ptr] is written on the clock edge.
  - Read: combinational, dout = mem[rd_ptr] when !empty.
- Pointers: ADDR_W bits wide; wrap naturally from 2**ADDR_W-1 to 0. count is held as a separate ADDR_W+1 bit register.
- Effective operations per cycle:
  - do_wr = wr & (~full | rd)
  - do_rd = rd & ~empty
- Write latency: a byte written at edge N appears on dout (if the FIFO was empty) and is counted in count/empty right after edge N. This is one cycle from the wr pulse to visibility.
- Pop: on an edge with do_rd, rd_ptr advances. The next entry (or 8'h00 if now empty) is shown after that edge.
- Count update rules:
  - do_wr & ~do_rd: count+1.
  - do_rd & ~do_wr: count-1.
  - both or neither: count unchanged.
- Boundary conditions:
  - Empty with wr&rd: the read is ignored and the write happens; count becomes 1.
  - Full with wr&rd: pop and write in the same cycle; count stays at max; no overflow.
  - Full with wr and no rd: din is discarded; memory, pointers and count are unchanged; overflow is set to 1.
  - rd while empty: no effect; no error flag.
  - overflow stays 1 until clr_overflow=1 at an edge. If a drop and clr_overflow coincide, set wins (overflow stays 1).
- Flags: empty, full and almost_full are combinational decodes of the count register. They are glitch-free relative to clk and change only after edges.
- Reset mid-operation: all contents are logically lost at once (count=0); no in-flight write completes.
- No other internal state machine; wr is assumed to be a 1-cycle pulse. A multi-cycle wr writes once per cycle.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release → empty=1, full=0, count=0, dout=8'h00, overflow=0.
- Single byte: wr pulse with din=8'hA5 → next cycle count=1, empty=0, dout=8'hA5. Then rd pulse → count=0, empty=1, dout=8'h00.
- Fill and order: write 16 bytes 8'h00..8'h0F →
  - almost_full rises when count reaches 12.
  - full=1 at count=16.
  - 16 pops return 8'h00..8'h0F in order, then empty=1.
- Overflow: fill to 16, then wr din=8'hFF without rd → count stays 16, overflow=1, and popped data never contains 8'hFF. clr_overflow pulse → overflow=0.
- Simultaneous ops:
  - At count=16, wr(8'h55)&rd → count=16, overflow=0, 8'h55 is the last entry out.
  - At empty, wr(8'h33)&rd → count=1, dout=8'h33.
- Wrap and async reset: push/pop 40 bytes at a steady occupancy of about 3 so the pointers wrap twice → data order is preserved. Assert reset mid-stream between edges → count=0, empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: first-word-fall-through read side,
// occupancy/almost-full flags and a sticky overflow indicator.
module uart_rx_fifo #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [7:0]        din,
  input  logic              rd,
  output logic [7:0]        dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              do_wr, do_rd, drop;

  // Strobe semantics: wr is accepted when not full, or when full and a pop
  // happens at the same edge; rd is accepted only when not empty. A refused
  // rd is silently ignored; a refused wr is dropped and raises overflow.
  always_comb begin
    do_wr      = wr & (~full | rd);
    do_rd      = rd & ~empty;
    drop       = wr & full & ~rd;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop coinciding with a clear keeps the flag set.
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally left unreset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == FULL_CNT);
    almost_full = (count_q >= AF_CNT);
    count       = count_q;
    overflow    = overflow_q;
    dout        = empty ? 8'h00 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo, checked against a queue model
// of the FIFO contents and the overflow flag.
module tb_uart_rx_fifo;

  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr;
  logic [7:0]        din;
  logic              rd;
  logic [7:0]        dout;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf;

  uart_rx_fifo #(.ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .din          (din),
    .rd           (rd),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    int sz;
    logic [7:0] head;
    sz   = exp_q.size();
    head = (sz > 0) ? exp_q[0] : 8'h00;
    check_eq({tag, ".count"},  32'(count),       32'(sz));
    check_eq({tag, ".empty"},  32'(empty),       32'(sz == 0));
    check_eq({tag, ".full"},   32'(full),        32'(sz == DEPTH));
    check_eq({tag, ".af"},     32'(almost_full), 32'(sz >= AF_LEVEL));
    check_eq({tag, ".ovf"},    32'(overflow),    32'(exp_ovf));
    check_eq({tag, ".dout"},   32'(dout),        32'(head));
  endtask

  // Reference: pop first if anything is stored, then push if a slot is free.
  task automatic model_edge(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit popped;
    bit dropped;
    popped  = r && (exp_q.size() > 0);
    dropped = 1'b0;
    if (popped) void'(exp_q.pop_front());
    if (w) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else dropped = 1'b1;
    end
    if (dropped) exp_ovf = 1'b1;
    else if (c)  exp_ovf = 1'b0;
  endtask

  // driver: apply one cycle of strobes, then check just after the edge
  task automatic step(input string tag, input logic w, input logic [7:0] d,
                      input logic r, input logic c);
    wr = w; din = d; rd = r; clr_overflow = c;
    @(posedge clk);
    model_edge(w, d, r, c);
    #1;
    wr = 1'b0; rd = 1'b0; clr_overflow = 1'b0; din = 8'h00;
    check_all(tag);
  endtask

  initial begin
    exp_ovf      = 1'b0;
    reset        = 1'b0;
    wr           = 1'b0;
    rd           = 1'b0;
    din          = 8'h00;
    clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check_all("idle");

    // single byte
    step("single_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("single_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    step("rd_empty",  1'b0, 8'h00, 1'b1, 1'b0);

    // fill and order
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("ovf_drop", 1'b1, 8'hFF, 1'b0, 1'b0);
    step("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    step("ovf_clr",  1'b0, 8'h00, 1'b0, 1'b1);
    step("full_wr_rd", 1'b1, 8'h55, 1'b1, 1'b0);
    step("drop_clr", 1'b1, 8'hEE, 1'b0, 1'b1);
    step("ovf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous at empty
    step("empty_wr_rd", 1'b1, 8'h33, 1'b1, 1'b0);
    step("empty_wr_rd_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // wrap at steady occupancy of 3
    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("wrap", 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);

    // async reset between edges
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_all("async_rst");
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst");

    // randomized phases biasing towards filling or draining
    for (int ph = 0; ph < 12; ph++) begin
      int wp;
      int rp;
      wp = (ph % 2 == 0) ? 80 : 30;
      rp = (ph % 2 == 0) ? 25 : 75;
      for (int i = 0; i < 120; i++) begin
        step("rand",
             logic'($urandom_range(0, 99) < wp),
             8'($urandom_range(0, 255)),
             logic'($urandom_range(0, 99) < rp),
             logic'($urandom_range(0, 99) < 5));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
